af_sweep_ctrl: RTL and testbench

AF_SWEEP_CTRL -- requirements
Module: af_sweep_ctrl

---
 rtl/af_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_af_sweep_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/af_sweep_ctrl.sv
// af_sweep_ctrl: contrast-detect autofocus controller, coarse then fine VCM lens sweep
module af_sweep_ctrl #(
   parameter int COARSE_STEP   = 32,
   parameter int FINE_STEP     = 4,
   parameter int SETTLE_FRAMES = 2,
   parameter int STEP_MAX      = 1023
) (
   input  logic        VIDEO_CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic        FRAME_END,
   input  logic [23:0] SHARP,
   input  logic        VCM_ACK,
   output logic [9:0]  VCM_STEP,
   output logic        VCM_REQ,
   output logic        BUSY,
   output logic        DONE,
   output logic [9:0]  BEST_STEP,
   output logic [2:0]  STATE
);
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WRITE    = 3'd1,
      S_SETTLE   = 3'd2,
      S_MEASURE  = 3'd3,
      S_NEXT     = 3'd4,
      S_FINAL_WR = 3'd5,
      S_FDONE    = 3'd6
   } state_t;

   localparam int          CW         = $clog2(SETTLE_FRAMES + 2);
   localparam logic [CW-1:0] C_CNT_LAST = CW'(SETTLE_FRAMES - 1);
   localparam logic [10:0] C_COARSE   = 11'(COARSE_STEP);
   localparam logic [10:0] C_FINE     = 11'(FINE_STEP);
   localparam logic [10:0] C_MAX      = 11'(STEP_MAX);

   state_t        r_state, w_next;
   logic          r_phase, w_phase;
   logic [9:0]    r_step, w_step;
   logic          r_req, w_req;
   logic          r_busy, w_busy;
   logic          r_done, w_done;
   logic [9:0]    r_best_step, w_best_step;
   logic [23:0]   r_best, w_best;
   logic [10:0]   r_hi, w_hi;
   logic [CW-1:0] r_cnt, w_cnt;

   // 11-bit sums so a step past STEP_MAX (or past the fine window) is detected, not wrapped
   logic [10:0] w_n_coarse, w_n_fine, w_lo_diff, w_hi_sum, w_hi_new;
   logic [9:0]  w_lo;
   logic        w_c_ovf, w_f_ovf;

   assign w_n_coarse = {1'b0, r_step} + C_COARSE;
   assign w_n_fine   = {1'b0, r_step} + C_FINE;
   assign w_c_ovf    = w_n_coarse > C_MAX;
   assign w_f_ovf    = w_n_fine > r_hi;
   assign w_lo_diff  = {1'b0, r_best_step} - C_COARSE;
   assign w_lo       = ({1'b0, r_best_step} >= C_COARSE) ? w_lo_diff[9:0] : 10'd0;
   assign w_hi_sum   = {1'b0, r_best_step} + C_COARSE;
   assign w_hi_new   = (w_hi_sum > C_MAX) ? C_MAX : w_hi_sum;

   // state register
   always_ff @(posedge VIDEO_CLK) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state logic; ACK only matters in the two write states, where VCM_REQ is high
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_FDONE: w_next = START ? S_WRITE : r_state;
         S_WRITE:         w_next = VCM_ACK ? ((SETTLE_FRAMES == 0) ? S_MEASURE : S_SETTLE) : r_state;
         S_SETTLE:        w_next = (FRAME_END && r_cnt == C_CNT_LAST) ? S_MEASURE : r_state;
         S_MEASURE:       w_next = FRAME_END ? S_NEXT : r_state;
         S_NEXT:          w_next = (r_phase && w_f_ovf) ? S_FINAL_WR : S_WRITE;
         S_FINAL_WR:      w_next = VCM_ACK ? S_FDONE : r_state;
         default:         w_next = S_IDLE;
      endcase
   end

   // next values of datapath and outputs; everything is registered below
   always_comb begin
      w_phase     = r_phase;
      w_step      = r_step;
      w_busy      = r_busy;
      w_done      = r_done;
      w_best_step = r_best_step;
      w_best      = r_best;
      w_hi        = r_hi;
      w_cnt       = r_cnt;
      case (r_state)
         S_IDLE, S_FDONE: begin
            if (START) begin
               w_phase     = 1'b0;
               w_step      = 10'd0;
               w_best      = 24'd0;
               w_best_step = 10'd0;
               w_cnt       = '0;
               w_busy      = 1'b1;
               w_done      = 1'b0;
            end
         end
         S_SETTLE: w_cnt = FRAME_END ? ((r_cnt == C_CNT_LAST) ? '0 : r_cnt + 1'b1) : r_cnt;
         S_MEASURE: begin
            if (FRAME_END && SHARP > r_best) begin
               w_best      = SHARP;
               w_best_step = r_step;
            end
         end
         S_NEXT: begin
            if (!r_phase) begin
               w_step  = w_c_ovf ? w_lo : w_n_coarse[9:0];
               w_phase = w_c_ovf;
               w_hi    = w_c_ovf ? w_hi_new : r_hi;
            end else begin
               w_step  = w_f_ovf ? r_best_step : w_n_fine[9:0];
            end
         end
         S_FINAL_WR: begin
            w_busy = VCM_ACK ? 1'b0 : r_busy;
            w_done = VCM_ACK ? 1'b1 : r_done;
         end
         default: ;
      endcase
      w_req = (w_next == S_WRITE) || (w_next == S_FINAL_WR);
   end

   // datapath and output registers
   always_ff @(posedge VIDEO_CLK) begin
      if (RESET) begin
         r_phase     <= 1'b0;
         r_step      <= 10'd0;
         r_req       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_best_step <= 10'd0;
         r_best      <= 24'd0;
         r_hi        <= 11'd0;
         r_cnt       <= '0;
      end else begin
         r_phase     <= w_phase;
         r_step      <= w_step;
         r_req       <= w_req;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_best_step <= w_best_step;
         r_best      <= w_best;
         r_hi        <= w_hi;
         r_cnt       <= w_cnt;
      end
   end

   assign VCM_STEP  = r_step;
   assign VCM_REQ   = r_req;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign BEST_STEP = r_best_step;
   assign STATE     = r_state;
endmodule

// File: tb/tb_af_sweep_ctrl.sv
// tb_af_sweep_ctrl: scoreboard bench with a lens/I2C responder model for af_sweep_ctrl
module tb_af_sweep_ctrl;
   typedef struct {
      int         cyc;
      string      name;
      logic [2:0] st;
      logic       rq;
      logic [9:0] stp;
      logic       bsy;
      logic       dn;
      logic [9:0] bst;
   } snap_t;
   typedef struct {
      logic [9:0] fin;
      int         nfr;
   } done_t;

   logic        clk = 0, rst = 1, start = 0;
   logic        ack_a = 0, ack_m = 0, fe_a = 0, fe_m = 0;
   logic [23:0] sharp_a = 0, sharp_m = 0;
   logic        ack, fe;
   logic [23:0] sharp;
   logic [9:0]  step, best;
   logic        req, busy, done;
   logic [2:0]  state;

   int          peak = 300;
   bit          flat = 0;
   logic [23:0] flatv = 0;
   bit          auto = 0;
   int          lens = 0;
   int          cyc = 0;
   int          tmo_n = 0;
   int          errors = 0, checks = 0;

   int    step_q[$];
   snap_t snap_q[$];
   done_t done_q[$];

   assign ack   = ack_a | ack_m;
   assign fe    = fe_a | fe_m;
   assign sharp = fe_m ? sharp_m : sharp_a;

   af_sweep_ctrl dut (
      .VIDEO_CLK(clk),
      .RESET(rst),
      .START(start),
      .FRAME_END(fe),
      .SHARP(sharp),
      .VCM_ACK(ack),
      .VCM_STEP(step),
      .VCM_REQ(req),
      .BUSY(busy),
      .DONE(done),
      .BEST_STEP(best),
      .STATE(state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] sharp_of(input int s);
      int d;
      d = (s > peak) ? s - peak : peak - s;
      return flat ? flatv : 24'(100000 - 10 * d);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_snap(input int c, input string n, input logic [2:0] st, input logic rq,
                              input logic [9:0] stp, input logic bsy, input logic dn, input logic [9:0] bst);
      snap_t s;
      s.cyc  = c;
      s.name = n;
      s.st   = st;
      s.rq   = rq;
      s.stp  = stp;
      s.bsy  = bsy;
      s.dn   = dn;
      s.bst  = bst;
      snap_q.push_back(s);
   endtask

   // I2C writer model: ACK five cycles after a request appears, lens moves to the acked code
   initial begin
      forever begin
         tick();
         if (auto && req) begin
            repeat (4) @(posedge clk);
            #1;
            ack_a = 1;
            lens  = int'(step);
            tick();
            ack_a = 0;
         end
      end
   end

   // sensor model: one frame every 8 cycles, sharpness of the current lens position
   initial begin
      forever begin
         repeat (7) @(posedge clk);
         #1;
         if (auto) begin
            fe_a    = 1;
            sharp_a = sharp_of(lens);
         end
         tick();
         fe_a = 0;
      end
   end

   // monitor: pops expectations when the DUT issues a request, finishes, or at a scheduled cycle
   initial begin
      logic  pr, pd;
      int    consumed, tseen, e;
      snap_t s;
      done_t d;
      pr = 0;
      pd = 0;
      consumed = 0;
      tseen = 0;
      forever begin
         @(negedge clk);
         if (tmo_n != tseen) begin
            tseen = tmo_n;
            checks++;
            errors++;
            $display("FAIL timeout: DONE not reached within cycle budget");
         end
         if (start && (state == 3'd0 || state == 3'd6)) consumed = 0;
         if (fe && (state == 3'd2 || state == 3'd3)) consumed++;
         if (req && !pr) begin
            checks++;
            if (step_q.size() == 0) begin
               errors++;
               $display("FAIL req_step: unexpected request at step %0d", step);
            end else begin
               e = step_q.pop_front();
               if (step !== 10'(e)) begin
                  errors++;
                  $display("FAIL req_step: got step %0d expected %0d", step, e);
               end
            end
         end
         pr = req;
         if (done && !pd) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL done: unexpected DONE");
            end else begin
               d = done_q.pop_front();
               if (step !== d.fin || best !== d.fin) begin
                  errors++;
                  $display("FAIL done_pos: got step %0d best %0d expected %0d", step, best, d.fin);
               end
               checks++;
               if (state !== 3'd6 || busy !== 1'b0) begin
                  errors++;
                  $display("FAIL done_status: got state %0d busy %0b expected 6 0", state, busy);
               end
               checks++;
               if (consumed != d.nfr) begin
                  errors++;
                  $display("FAIL frames: got %0d consumed expected %0d", consumed, d.nfr);
               end
               checks++;
               if (step_q.size() != 0) begin
                  errors++;
                  $display("FAIL step_count: %0d expected requests never issued", step_q.size());
               end
            end
         end
         pd = done;
         while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
            s = snap_q.pop_front();
            checks++;
            if (s.cyc != cyc || {state, req, step, busy, done, best} !== {s.st, s.rq, s.stp, s.bsy, s.dn, s.bst}) begin
               errors++;
               $display("FAIL %s: cyc %0d got state=%0d req=%0b step=%0d busy=%0b done=%0b best=%0d; expected cyc %0d state=%0d req=%0b step=%0d busy=%0b done=%0b best=%0d",
                        s.name, cyc, state, req, step, busy, done, best, s.cyc, s.st, s.rq, s.stp, s.bsy, s.dn, s.bst);
            end
         end
      end
   end

   task automatic run_sweep(input int pk, input bit fl, input logic [23:0] fv,
                            input int lo, input int last, input int fin, input int nfr);
      done_t d;
      peak  = pk;
      flat  = fl;
      flatv = fv;
      for (int s = 0; s <= 992; s += 32) step_q.push_back(s);
      for (int s = lo; s <= last; s += 4) step_q.push_back(s);
      step_q.push_back(fin);
      d.fin = 10'(fin);
      d.nfr = nfr;
      done_q.push_back(d);
      auto  = 1;
      start = 1;
      expect_snap(cyc + 1, "sweep_start", 3'd1, 1'b1, 10'd0, 1'b1, 1'b0, 10'd0);
      tick();
      start = 0;
      for (int i = 0; i < 6000 && !done; i++) tick();
      if (!done) tmo_n++;
      tick();
   endtask

   initial begin
      rst = 1;
      repeat (2) tick();
      expect_snap(cyc + 1, "reset", 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
      tick();
      rst = 0;
      tick();
      // peak 300: coarse best 288, fine 256..320, final 300, 49 x 3 frames
      run_sweep(300, 0, 24'd0, 256, 320, 300, 147);
      // peak at the lower edge: window clamps to 0..32
      run_sweep(0, 0, 24'd0, 0, 32, 0, 123);
      // peak at the upper edge: window 960..1023, fine stops at 1020
      run_sweep(1023, 0, 24'd0, 960, 1020, 1020, 144);
      // flat zero and flat constant: step 0 must win every tie
      run_sweep(0, 1, 24'd0, 0, 32, 0, 123);
      run_sweep(0, 1, 24'd5, 0, 32, 0, 123);

      auto = 0;
      repeat (3) tick();
      start = 1;
      step_q.push_back(0);
      expect_snap(cyc + 1, "start_write", 3'd1, 1'b1, 10'd0, 1'b1, 1'b0, 10'd0);
      tick();
      start = 0;
      repeat (2) tick();
      ack_m = 1;
      fe_m  = 1;
      expect_snap(cyc + 1, "ack_to_settle", 3'd2, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0);
      tick();
      ack_m = 0;
      fe_m  = 0;
      start = 1;
      expect_snap(cyc + 1, "start_ignored", 3'd2, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0);
      tick();
      start = 0;
      fe_m = 1;
      expect_snap(cyc + 1, "settle_one", 3'd2, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0);
      tick();
      fe_m = 0;
      tick();
      fe_m = 1;
      expect_snap(cyc + 1, "settle_two", 3'd3, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0);
      tick();
      sharp_m = 24'd7;
      expect_snap(cyc + 1, "measure", 3'd4, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0);
      tick();
      fe_m = 0;
      sharp_m = 24'd0;
      step_q.push_back(32);
      expect_snap(cyc + 1, "next_write", 3'd1, 1'b1, 10'd32, 1'b1, 1'b0, 10'd0);
      tick();
      for (int k = 2; k <= 5; k++) begin
         ack_m = 1;
         tick();
         ack_m = 0;
         repeat (3) begin
            fe_m = 1;
            tick();
            fe_m = 0;
         end
         step_q.push_back(k * 32);
         tick();
      end
      expect_snap(cyc, "at_160", 3'd1, 1'b1, 10'd160, 1'b1, 1'b0, 10'd0);
      rst = 1;
      expect_snap(cyc + 1, "reset_mid", 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
      tick();
      rst = 0;
      tick();
      ack_m = 1;
      expect_snap(cyc + 1, "late_ack", 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
      tick();
      ack_m = 0;
      expect_snap(cyc + 1, "after_late_ack", 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
      repeat (3) tick();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
